// File: rtl/serial_magnitude_compare.sv
// -----------------------------------------------------------------------------
// serial_magnitude_compare
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are latched on an
// accepted start strobe and walked MSB-first in 2-bit slices, one slice per
// clock. The walk stops at the first unequal slice; if every slice matches
// the operands are equal. The result is reported as one-hot gt/eq/lt flags
// together with a one-cycle done pulse.
//
// Signed compares invert bit WIDTH-1 of both operands when they are latched.
// That maps two's-complement order onto unsigned order, so the slice logic
// is the same in both modes.
//
// Handshake: start is a single-cycle request. It is accepted on a rising
// edge when busy = 0 (IDLE or DONE). While busy = 1 start is ignored, and so
// are operand or signed_mode changes.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   request strobe
//   a, b         in   operands (WIDTH bits), sampled on accept
//   signed_mode  in   1 = two's-complement compare, sampled on accept
//   busy         out  high while scanning slices
//   done         out  one-cycle result-valid pulse
//   gt, eq, lt   out  one-hot result; all zero while busy
//   slice_idx    out  index of the slice under compare (debug)
//   state_dbg    out  raw FSM state (debug)
// -----------------------------------------------------------------------------
module serial_magnitude_compare #(
    parameter  int WIDTH = 32,
    localparam int S     = WIDTH / 2,
    localparam int IW    = (S > 1) ? $clog2(S) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [IW-1:0]    slice_idx,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]    TOP_IDX   = IW'(S - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    logic [1:0]       w_sa;
    logic [1:0]       w_sb;
    logic             w_slice_gt;
    logic             w_slice_lt;
    logic             w_accept;
    logic [WIDTH-1:0] w_flip;

    // Current slice: bits [2*idx+1 : 2*idx]. The index is widened by one bit
    // so the doubled offset cannot wrap.
    assign w_sa = r_a[{r_idx, 1'b0} +: 2];
    assign w_sb = r_b[{r_idx, 1'b0} +: 2];

    // 2-bit compare cell: the high bit decides unless the high bits match.
    assign w_slice_gt = (w_sa[1] & ~w_sb[1]) | (~(w_sa[1] ^ w_sb[1]) & w_sa[0] & ~w_sb[0]);
    assign w_slice_lt = (~w_sa[1] & w_sb[1]) | (~(w_sa[1] ^ w_sb[1]) & ~w_sa[0] & w_sb[0]);

    assign w_accept = start && (r_state != ST_SCAN);
    assign w_flip   = signed_mode ? SIGN_MASK : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_slice_gt) begin
                        r_gt    <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_slice_lt) begin
                        r_lt    <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_idx == '0) begin
                        r_eq    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; flags from the
                    // previous compare are held until then.
                    if (w_accept) begin
                        r_a     <= a ^ w_flip;
                        r_b     <= b ^ w_flip;
                        r_idx   <= TOP_IDX;
                        r_gt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_state <= ST_SCAN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs are decodes of registered state only.
    assign busy      = (r_state == ST_SCAN);
    assign done      = (r_state == ST_DONE);
    assign gt        = r_gt;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign slice_idx = r_idx;
    assign state_dbg = r_state;

endmodule
